// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: steps the shared FP MAC through synchronous Maxnet iterations until one neuron survives.
module maxnet_ctrl #(
    parameter int MAX_ITER = 15,
    parameter int MAC_LAT  = 1,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        nz_flags,
    output logic              load_en,
    output logic [1:0]        row_sel,
    output logic [1:0]        col_sel,
    output logic              mac_en,
    output logic              mac_first,
    output logic              nxt_we,
    output logic              commit,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              no_winner,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_cnt
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_ACC    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_WR     = 3'd5;
    localparam logic [2:0] S_COMMIT = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;
    localparam logic [2:0] LAT_LAST = 3'(MAC_LAT > 0 ? MAC_LAT - 1 : 0);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    logic [2:0]        state_q, state_d, lat_q, lat_d, pop;
    logic [1:0]        row_q, row_d, col_q, col_d, winner_q, winner_d, idx;
    logic              no_winner_q, no_winner_d, timeout_q, timeout_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    always_comb begin
        pop = {2'b0, nz_flags[0]} + {2'b0, nz_flags[1]} + {2'b0, nz_flags[2]} + {2'b0, nz_flags[3]};
        idx = nz_flags[3] ? 2'd3 : nz_flags[2] ? 2'd2 : nz_flags[1] ? 2'd1 : 2'd0;
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        row_d       = row_q;
        col_d       = col_q;
        winner_d    = winner_q;
        no_winner_d = no_winner_q;
        timeout_d   = timeout_q;
        iter_d      = iter_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    iter_d      = '0;
                    winner_d    = 2'd0;
                    no_winner_d = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            S_LOAD: state_d = S_CHECK;
            S_CHECK: begin
                row_d = 2'd0;
                col_d = 2'd0;
                if (pop == 3'd1) begin
                    state_d  = S_DONE;
                    winner_d = idx;
                end else if (pop == 3'd0) begin
                    state_d     = S_DONE;
                    no_winner_d = 1'b1;
                    winner_d    = 2'd0;
                end else if (iter_q == ITER_MAX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    winner_d  = 2'd0;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    lat_d   = LAT_LAST;
                    state_d = (MAC_LAT == 0) ? S_WR : S_DRAIN;
                end
            end
            S_DRAIN: begin
                lat_d   = lat_q - 3'd1;
                state_d = (lat_q == 3'd0) ? S_WR : S_DRAIN;
            end
            S_WR: begin
                row_d   = row_q + 2'd1;
                state_d = (row_q == 2'd3) ? S_COMMIT : S_ACC;
            end
            S_COMMIT: begin
                iter_d  = iter_q + ITER_W'(iter_q != {ITER_W{1'b1}});
                state_d = S_CHECK;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lat_q       <= 3'd0;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            winner_q    <= 2'd0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            row_q       <= row_d;
            col_q       <= col_d;
            winner_q    <= winner_d;
            no_winner_q <= no_winner_d;
            timeout_q   <= timeout_d;
            iter_q      <= iter_d;
        end
    end

    assign load_en   = state_q == S_LOAD;
    assign mac_en    = state_q == S_ACC;
    assign mac_first = (state_q == S_ACC) && (col_q == 2'd0);
    assign nxt_we    = state_q == S_WR;
    assign commit    = state_q == S_COMMIT;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign row_sel   = row_q;
    assign col_sel   = col_q;
    assign winner    = winner_q;
    assign no_winner = no_winner_q;
    assign timeout   = timeout_q;
    assign iter_cnt  = iter_q;
endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb_maxnet_ctrl: four controller instances (default, MAX_ITER=2, MAC_LAT=0, MAC_LAT=3) checked cycle by cycle.
module tb_maxnet_ctrl;
    localparam int NI = 4;

    function automatic int mi_of(input int g);
        return (g == 1) ? 2 : 15;
    endfunction

    function automatic int ml_of(input int g);
        return (g == 2) ? 0 : (g == 3) ? 3 : 1;
    endfunction

    typedef struct packed {
        logic [3:0] nz;
        logic       chk_col;
        logic       ld, me, mf, we, cm, bz, dn;
        logic [1:0] row, col, win;
        logic       nw, to;
        logic [7:0] it;
    } vec_t;

    typedef struct {
        int         g;
        logic [3:0] nz0, nzr;
        logic [1:0] win;
        logic       nw, to;
        int         it, lat;
    } tv_t;

    logic       clk;
    logic       rst_n[NI], start[NI], load_en[NI], mac_en[NI], mac_first[NI], nxt_we[NI];
    logic       commit[NI], busy[NI], done[NI], no_winner[NI], timeout[NI];
    logic [3:0] nz[NI];
    logic [1:0] row_sel[NI], col_sel[NI], winner[NI];
    logic [7:0] iter_cnt[NI];

    for (genvar i = 0; i < NI; i++) begin : g_dut
        maxnet_ctrl #(.MAX_ITER(mi_of(i)), .MAC_LAT(ml_of(i)), .ITER_W(8)) u_dut (
            .clk(clk), .rst_n(rst_n[i]), .start(start[i]), .nz_flags(nz[i]),
            .load_en(load_en[i]), .row_sel(row_sel[i]), .col_sel(col_sel[i]),
            .mac_en(mac_en[i]), .mac_first(mac_first[i]), .nxt_we(nxt_we[i]),
            .commit(commit[i]), .busy(busy[i]), .done(done[i]), .winner(winner[i]),
            .no_winner(no_winner[i]), .timeout(timeout[i]), .iter_cnt(iter_cnt[i])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    real  av[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic vec_t obs(input int g);
        vec_t v;
        v = '0;
        v.chk_col = 1'b1;
        v.ld = load_en[g]; v.me = mac_en[g]; v.mf = mac_first[g]; v.we = nxt_we[g];
        v.cm = commit[g]; v.bz = busy[g]; v.dn = done[g];
        v.row = row_sel[g]; v.col = col_sel[g]; v.win = winner[g];
        v.nw = no_winner[g]; v.to = timeout[g]; v.it = iter_cnt[g];
        return v;
    endfunction

    function automatic vec_t masked(input vec_t a, input vec_t e);
        vec_t r;
        r = a;
        r.nz = e.nz;
        r.chk_col = e.chk_col;
        if (!e.chk_col) r.col = e.col;
        return r;
    endfunction

    function automatic vec_t base(input int it);
        vec_t v;
        v = '0;
        v.chk_col = 1'b1;
        v.bz = 1'b1;
        v.it = 8'(it);
        return v;
    endfunction

    // Outcome straight from the stopping rules: walk the per-iteration nonzero vectors.
    task automatic outcome(input logic [3:0] seq[$], input int mi, output int k,
                           output logic [1:0] w, output logic nw, output logic to);
        int p;
        k = 0; w = 2'd0; nw = 1'b0; to = 1'b0;
        forever begin
            p = $countones(seq[k]);
            if (p == 1) begin
                for (int i = 0; i < 4; i++) if (seq[k][i]) w = 2'(i);
                return;
            end
            if (p == 0) begin nw = 1'b1; return; end
            if (k == mi) begin to = 1'b1; return; end
            k++;
        end
    endtask

    task automatic build(input int g, input logic [3:0] seq[$], output int k,
                         output logic [1:0] w, output logic nw, output logic to);
        vec_t v;
        outcome(seq, mi_of(g), k, w, nw, to);
        exp_q.delete();
        v = base(0); v.ld = 1'b1; exp_q.push_back(v);
        for (int it = 0; it <= k; it++) begin
            v = base(it); v.nz = seq[it]; exp_q.push_back(v);
            if (it == k) break;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    v = base(it); v.me = 1'b1; v.mf = (c == 0); v.row = 2'(r); v.col = 2'(c);
                    exp_q.push_back(v);
                end
                for (int d = 0; d < ml_of(g); d++) begin
                    v = base(it); v.chk_col = 1'b0; v.row = 2'(r); exp_q.push_back(v);
                end
                v = base(it); v.chk_col = 1'b0; v.row = 2'(r); v.we = 1'b1; exp_q.push_back(v);
            end
            v = base(it); v.cm = 1'b1; exp_q.push_back(v);
        end
        v = base(k); v.dn = 1'b1; v.win = w; v.nw = nw; v.to = to; exp_q.push_back(v);
        v.dn = 1'b0; v.bz = 1'b0; exp_q.push_back(v);
    endtask

    task automatic run(input int g, input logic [3:0] seq[$], input int poke, input int abort,
                       output int lat, output logic [1:0] w, output logic nw, output logic to,
                       output logic [7:0] it);
        int         k;
        logic [1:0] mw;
        logic       mnw, mto;
        vec_t       zero;
        zero = '0;
        zero.chk_col = 1'b1;
        build(g, seq, k, mw, mnw, mto);
        lat = -1;
        @(negedge clk);
        start[g] = 1'b1;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            chk($sformatf("g%0d_cyc%0d", g, c), 64'(masked(obs(g), exp_q[c])), 64'(exp_q[c]));
            if (done[g] && lat < 0) lat = c + 1;
            if (c == abort) begin
                rst_n[g] = 1'b0;
                #1;
                chk("rst_async", 64'(obs(g)), 64'(zero));
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold", 64'(obs(g)), 64'(zero));
                end
                start[g] = 1'b0;
                rst_n[g] = 1'b1;
                w = 2'd0; nw = 1'b0; to = 1'b0; it = 8'd0;
                return;
            end
            nz[g] = exp_q[c].nz;
            start[g] = (c == poke);
        end
        start[g] = 1'b0;
        w = winner[g]; nw = no_winner[g]; to = timeout[g]; it = iter_cnt[g];
    endtask

    // Behavioural datapath: a_i <- relu(a_i - 0.2 * sum_{j!=i} a_j), all rows from the same vector.
    task automatic dp_seq(output logic [3:0] seq[$]);
        real        a[4], n[4], s;
        logic [3:0] f;
        a = av;
        seq.delete();
        for (int t = 0; t < 17; t++) begin
            s = 0.0;
            for (int i = 0; i < 4; i++) begin
                f[i] = a[i] > 0.0;
                s += a[i];
            end
            seq.push_back(f);
            for (int i = 0; i < 4; i++) begin
                n[i] = a[i] - 0.2 * (s - a[i]);
                if (n[i] < 0.0) n[i] = 0.0;
            end
            a = n;
        end
    endtask

    initial begin
        tv_t        tv[10];
        logic [3:0] seq[$];
        vec_t       zero;
        int         lat, k, g;
        logic [1:0] w, mw;
        logic       nw, to, mnw, mto;
        logic [7:0] it;

        tv[0] = '{0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, 0, 3};
        tv[1] = '{0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 0, 3};
        tv[2] = '{1, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b1, 2, 55};
        tv[3] = '{0, 4'b1011, 4'b1000, 2'd3, 1'b0, 1'b0, 1, 29};
        tv[4] = '{2, 4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0, 1, 25};
        tv[5] = '{3, 4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0, 1, 37};
        tv[6] = '{0, 4'b1100, 4'b0000, 2'd0, 1'b1, 1'b0, 1, 29};
        tv[7] = '{1, 4'b0011, 4'b0011, 2'd0, 1'b0, 1'b1, 2, 55};
        tv[8] = '{3, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0, 1, 37};
        tv[9] = '{0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b1, 15, 393};

        zero = '0;
        zero.chk_col = 1'b1;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; nz[i] = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) chk("reset", 64'(obs(i)), 64'(zero));
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("idle", 64'(obs(i)), 64'(zero));

        for (int t = 0; t < 10; t++) begin
            seq.delete();
            seq.push_back(tv[t].nz0);
            repeat (16) seq.push_back(tv[t].nzr);
            run(tv[t].g, seq, -1, -1, lat, w, nw, to, it);
            chk($sformatf("tv%0d_lat", t), 64'(lat), 64'(tv[t].lat));
            chk($sformatf("tv%0d_win", t), 64'(w), 64'(tv[t].win));
            chk($sformatf("tv%0d_nw", t), 64'(nw), 64'(tv[t].nw));
            chk($sformatf("tv%0d_to", t), 64'(to), 64'(tv[t].to));
            chk($sformatf("tv%0d_it", t), 64'(it), 64'(tv[t].it));
        end

        seq.delete();
        seq.push_back(4'b1111);
        repeat (16) seq.push_back(4'b0100);
        run(0, seq, 3, -1, lat, w, nw, to, it);
        chk("poke_lat", 64'(lat), 64'(29));
        chk("poke_win", 64'(w), 64'(2));
        run(0, seq, -1, 6, lat, w, nw, to, it);
        chk("abort_nodone", 64'(lat), 64'(-1));
        run(0, seq, -1, -1, lat, w, nw, to, it);
        chk("rerun_lat", 64'(lat), 64'(29));
        chk("rerun_win", 64'(w), 64'(2));

        av[0] = 0.3; av[1] = 0.5; av[2] = 0.7; av[3] = 0.9;
        dp_seq(seq);
        for (int i = 0; i < NI; i++) begin
            if (i == 1) continue;
            run(i, seq, -1, -1, lat, w, nw, to, it);
            chk($sformatf("dp%0d_win", i), 64'(w), 64'(3));
            chk($sformatf("dp%0d_it", i), 64'(it), 64'(5));
            chk($sformatf("dp%0d_lat", i), 64'(lat), 64'(3 + 5 * (4 * (5 + ml_of(i)) + 2)));
        end

        for (int n = 0; n < 60; n++) begin
            g = $urandom_range(0, NI - 1);
            seq.delete();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++)
                    av[i] = ($urandom_range(0, 3) == 0) ? 0.0 : real'($urandom_range(1, 1000)) / 1000.0;
                dp_seq(seq);
            end else begin
                repeat (17) seq.push_back(4'($urandom_range(0, 15)));
            end
            run(g, seq, -1, -1, lat, w, nw, to, it);
            outcome(seq, mi_of(g), k, mw, mnw, mto);
            chk("rnd_win", 64'(w), 64'(mw));
            chk("rnd_nw", 64'(nw), 64'(mnw));
            chk("rnd_to", 64'(to), 64'(mto));
            chk("rnd_it", 64'(it), 64'(k));
            chk("rnd_lat", 64'(lat), 64'(3 + k * (4 * (5 + ml_of(g)) + 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/maxnet_ctrl.md
# maxnet_ctrl

Sequencing controller for the 4-neuron Maxnet datapath. On `start` it loads the input activations, then runs synchronous-update iterations by stepping the shared multiply-accumulate unit through the 4×4 weight matrix (row = neuron, column = term), one row at a time. It repeats until exactly one activation is non-zero, all are zero, or an iteration limit is hit, then reports the winner index and status. It sits between the top-level host handshake and the FP MAC / activation-register datapath; the weight matrix itself is constant (1.0 diagonal, -0.2 off-diagonal).

## Interface
- `MAX_ITER`, 15: maximum update iterations before timeout (≥1).
- `MAC_LAT`, 1: cycles between the last `mac_en` of a row and a valid MAC result (0..7).
- `ITER_W`, 8: width of `iter_cnt`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `nz_flags`  in  4  bit i = current activation i is > 0 (after ReLU), valid one cycle after `load_en` / `commit`.
- `load_en`  out  1  capture external inputs into activation registers.
- `row_sel`  out  2  neuron whose next activation is being computed.
- `col_sel`  out  2  weight column / activation term currently fed to the MAC.
- `mac_en`  out  1  MAC accumulates W[row_sel][col_sel]·a[col_sel].
- `mac_first`  out  1  with `mac_en`: load the product instead of adding to it.
- `nxt_we`  out  1  write MAC result (ReLU applied in datapath) into next-activation register `row_sel`.
- `commit`  out  1  copy all four next-activation registers to current.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `winner`  out  2  index of the surviving neuron.
- `no_winner`  out  1  run ended with all activations zero.
- `timeout`  out  1  run ended at `MAX_ITER` with >1 non-zero.
- `iter_cnt`  out  ITER_W  iterations completed in the current/last run.

## Operation
- States: IDLE, LOAD, CHECK, ACC, DRAIN, WR, COMMIT, DONE.
- IDLE: `start`=1 → LOAD; clear `iter_cnt`, `winner`, `no_winner`, `timeout`.
- LOAD (1 cycle): `load_en`=1 → CHECK.
- CHECK (1 cycle): evaluate popcount(`nz_flags`):
  - ==1 → DONE; `winner` ← index of the set bit.
  - ==0 → DONE; `no_winner` ← 1, `winner` ← 0.
  - ≥2 and `iter_cnt`==`MAX_ITER` → DONE; `timeout` ← 1, `winner` ← 0.
  - otherwise → ACC with `row_sel`=0, `col_sel`=0.
- ACC (4 cycles per row): `mac_en`=1, `col_sel` 0,1,2,3; `mac_first`=1 only at `col_sel`=0. After col 3 → DRAIN (or WR if `MAC_LAT`=0).
- DRAIN: `MAC_LAT` cycles, all strobes low → WR.
- WR (1 cycle): `nxt_we`=1 for `row_sel`. If `row_sel`<3: `row_sel`+1 → ACC. If `row_sel`==3 → COMMIT.
- COMMIT (1 cycle): `commit`=1, `iter_cnt`+1 (saturates at all-ones) → CHECK.
- DONE (1 cycle): `done`=1 → IDLE.
- Status outputs and `iter_cnt` hold from DONE until the next accepted `start`.
- `start` outside IDLE is ignored; it is not queued.
- `row_sel`/`col_sel` return to 0 in every state except ACC/DRAIN/WR.
- Synchronous update: no current activation changes until COMMIT, so all rows of one iteration use the same activation vector.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, `iter_cnt`=0.
- Reset mid-run: aborts immediately, returns to reset values; no `done`.
- All outputs are registered or pure functions of the state register; no input-to-output combinational paths.
- `start` high at edge N → `load_en` in cycle N+1, CHECK in N+2.
- Row cost = 4 + `MAC_LAT` + 1 cycles; iteration = 4·(5+`MAC_LAT`) + 2 cycles (COMMIT + CHECK); 26 cycles at defaults.
- Run latency from `start` edge to `done`: 3 + k·(4·(5+`MAC_LAT`)+2) cycles for k iterations.
- `busy` rises the cycle after `start` is accepted, falls the cycle after `done`.

## Test plan
- Single positive input (nz_flags=0010 after load) → `done` at start+3, `winner`=1, `iter_cnt`=0, no `mac_en` pulses.
- All-zero inputs (nz_flags=0000) → `done` at start+3, `no_winner`=1.
- Behavioural datapath, inputs {0.3, 0.5, 0.7, 0.9} → converges with `winner`=3; check strobe sequence per row (4 `mac_en`, `mac_first` on col 0, `nxt_we` after `MAC_LAT` gap, `commit` after row 3) and 26 cycles per iteration.
- `MAX_ITER`=2, nz_flags forced 1111 → `done` after 2 iterations (55 cycles), `timeout`=1, `iter_cnt`=2.
- `start` pulsed during ACC → ignored; `rst_n` low during DRAIN → all outputs 0 at once, no `done`; a fresh `start` then runs normally.
- `MAC_LAT`=0 and `MAC_LAT`=3 → row cost 5 and 8 cycles respectively; results identical.
